pc_unit: RTL and testbench

Parametrised program-counter unit for the CPU fetch stage, replacing the bare PC register. It holds the fetch address, selects the next PC from sequential, branch, jump, register-jump, return, exception and exception-return sources under a fixed priority, and supports pipeline stalls. It also keeps an exception PC (EPC) and a small circular return-address stack (RAS) for call/return. All state updates on the rising edge of `clk`.

---
 rtl/pc_unit.sv | 113 +++++++++++
 tb/tb_pc_unit.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/pc_unit.sv
// Fetch-stage program counter: prioritised next-PC selection, exception PC,
// and a circular return-address stack for call/return prediction.
module pc_unit #(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter logic [WIDTH-1:0] TRAP_VECTOR  = WIDTH'(32'h0000_0180),
  parameter int               INC          = 4,
  parameter int               RAS_DEPTH    = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    stall,
  input  logic                    exc,
  input  logic                    eret,
  input  logic                    br_taken,
  input  logic signed [WIDTH-1:0] br_offset,
  input  logic                    jmp,
  input  logic        [WIDTH-1:0] jmp_target,
  input  logic                    jr,
  input  logic        [WIDTH-1:0] jr_target,
  input  logic                    call,
  input  logic                    ret,
  output logic        [WIDTH-1:0] pc_o,
  output logic        [WIDTH-1:0] pc_plus4_o,
  output logic        [WIDTH-1:0] epc_o,
  output logic                    ras_empty_o,
  output logic                    ras_full_o,
  output logic                    misalign_o
);

  localparam int               PTR_W   = $clog2(RAS_DEPTH);
  localparam int               CNT_W   = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RAS_DEPTH);

  logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0] ras_top;
  logic [CNT_W-1:0] ras_cnt;
  logic [WIDTH-1:0] pc_nxt;
  logic             ras_push;
  logic             ras_pop;
  logic             ras_replace;
  logic [PTR_W-1:0] ras_wr_ptr;

  function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + 1'b1;
  endfunction

  function automatic logic [CNT_W-1:0] cnt_sat_dec(input logic [CNT_W-1:0] c);
    return (c == '0) ? c : c - 1'b1;
  endfunction

  assign pc_plus4_o  = pc_o + WIDTH'(INC);
  assign misalign_o  = |pc_o[1:0];
  assign ras_empty_o = (ras_cnt == '0);
  assign ras_full_o  = (ras_cnt == CNT_MAX);

  // call only acts when a ret/jr/jmp source actually wins the PC mux
  always_comb begin
    pc_nxt   = pc_plus4_o;
    ras_push = 1'b0;
    ras_pop  = 1'b0;
    if (exc) begin
      pc_nxt = TRAP_VECTOR;
    end else if (eret) begin
      pc_nxt = epc_o;
    end else if (stall) begin
      pc_nxt = pc_o;
    end else if (ret) begin
      pc_nxt   = ras_empty_o ? jr_target : ras_mem[ras_top];
      ras_pop  = 1'b1;
      ras_push = call;
    end else if (jr) begin
      pc_nxt   = jr_target;
      ras_push = call;
    end else if (jmp) begin
      pc_nxt   = jmp_target;
      ras_push = call;
    end else if (br_taken) begin
      pc_nxt = pc_o + $unsigned(br_offset);
    end
  end

  // call+ret on a non-empty stack rewrites the top in place
  assign ras_replace = ras_push && ras_pop && !ras_empty_o;
  assign ras_wr_ptr  = ras_replace ? ras_top : ras_top + 1'b1;

  // Register stage: PC, EPC and RAS bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_o    <= RESET_VECTOR;
      epc_o   <= '0;
      ras_top <= '0;
      ras_cnt <= '0;
    end else begin
      pc_o <= pc_nxt;
      if (exc) epc_o <= pc_o;
      if (ras_replace) begin
        ras_cnt <= ras_cnt;
      end else if (ras_push) begin
        ras_top <= ras_top + 1'b1;
        ras_cnt <= cnt_sat_inc(ras_cnt);
      end else if (ras_pop && !ras_empty_o) begin
        ras_top <= ras_top - 1'b1;
        ras_cnt <= cnt_sat_dec(ras_cnt);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && ras_push) ras_mem[ras_wr_ptr] <= pc_plus4_o;
  end

endmodule

// File: tb/tb_pc_unit.sv
// Directed self-checking bench for pc_unit with default parameters.
module tb_pc_unit;

  logic               clk = 1'b0;
  logic               rst;
  logic               stall, exc, eret, br_taken, jmp, jr, call, ret;
  logic signed [31:0] br_offset;
  logic        [31:0] jmp_target, jr_target;
  logic        [31:0] pc_o, pc_plus4_o, epc_o;
  logic               ras_empty_o, ras_full_o, misalign_o;

  int n_tests = 0;
  int n_fail  = 0;

  pc_unit dut (
    .clk(clk), .rst(rst), .stall(stall), .exc(exc), .eret(eret),
    .br_taken(br_taken), .br_offset(br_offset), .jmp(jmp),
    .jmp_target(jmp_target), .jr(jr), .jr_target(jr_target),
    .call(call), .ret(ret), .pc_o(pc_o), .pc_plus4_o(pc_plus4_o),
    .epc_o(epc_o), .ras_empty_o(ras_empty_o), .ras_full_o(ras_full_o),
    .misalign_o(misalign_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    stall = 0; exc = 0; eret = 0; br_taken = 0; jmp = 0; jr = 0;
    call = 0; ret = 0; br_offset = '0; jmp_target = '0; jr_target = '0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic go_to(input logic [31:0] addr);
    idle(); jmp = 1; jmp_target = addr; step(); idle();
  endtask

  initial begin
    idle();
    rst = 1;
    step(); step();
    chk("rst_pc", pc_o, 32'h0);
    chk("rst_epc", epc_o, 32'h0);
    chk("rst_empty", 32'(ras_empty_o), 32'd1);
    chk("rst_full", 32'(ras_full_o), 32'd0);
    chk("rst_plus4", pc_plus4_o, 32'h4);
    chk("rst_misalign", 32'(misalign_o), 32'd0);
    rst = 0;
    step(); chk("seq_4", pc_o, 32'h4);
    step(); chk("seq_8", pc_o, 32'h8);
    step(); chk("seq_12", pc_o, 32'hC);
    rst = 1; step(); rst = 0;
    chk("rst_pulse_pc", pc_o, 32'h0);
    chk("rst_pulse_empty", 32'(ras_empty_o), 32'd1);

    // branches, wrap, misalignment
    go_to(32'h100);
    br_taken = 1; br_offset = -32'sd8; step(); idle();
    chk("br_neg", pc_o, 32'hF8);
    go_to(32'hFFFF_FFFC);
    chk("wrap_plus4", pc_plus4_o, 32'h0);
    step(); chk("wrap_seq", pc_o, 32'h0);
    go_to(32'h102);
    chk("misalign_pc", pc_o, 32'h102);
    chk("misalign_flag", 32'(misalign_o), 32'd1);

    // stall holds PC, then applies the pending jump
    go_to(32'h40);
    stall = 1; jmp = 1; jmp_target = 32'h200;
    step(); chk("stall_1", pc_o, 32'h40);
    step(); chk("stall_2", pc_o, 32'h40);
    step(); chk("stall_3", pc_o, 32'h40);
    stall = 0; step(); idle();
    chk("stall_release", pc_o, 32'h200);

    // call / return
    go_to(32'h10);
    call = 1; jmp = 1; jmp_target = 32'h300; step(); idle();
    chk("call_pc", pc_o, 32'h300);
    chk("call_nonempty", 32'(ras_empty_o), 32'd0);
    ret = 1; jr_target = 32'h999; step(); idle();
    chk("ret_pc", pc_o, 32'h14);
    chk("ret_empty", 32'(ras_empty_o), 32'd1);
    ret = 1; jr_target = 32'h88; step(); idle();
    chk("ret_fallback", pc_o, 32'h88);
    chk("ret_fallback_empty", 32'(ras_empty_o), 32'd1);

    // overflow: five pushes into four entries
    go_to(32'h1000);
    for (int i = 2; i <= 6; i++) begin
      call = 1; jmp = 1; jmp_target = 32'(i) << 12; step(); idle();
      if (i == 4) chk("ras_not_full_3", 32'(ras_full_o), 32'd0);
      if (i == 5) chk("ras_full_4", 32'(ras_full_o), 32'd1);
    end
    chk("ras_full_5", 32'(ras_full_o), 32'd1);
    chk("ovf_pc", pc_o, 32'h6000);
    ret = 1; jr_target = 32'h777; step(); chk("pop_1", pc_o, 32'h5004);
    chk("pop_1_notfull", 32'(ras_full_o), 32'd0);
    step(); chk("pop_2", pc_o, 32'h4004);
    step(); chk("pop_3", pc_o, 32'h3004);
    chk("pop_3_nonempty", 32'(ras_empty_o), 32'd0);
    step(); chk("pop_4", pc_o, 32'h2004);
    idle();
    chk("pop_4_empty", 32'(ras_empty_o), 32'd1);

    // lone call is ignored
    call = 1; step(); idle();
    chk("lone_call_pc", pc_o, 32'h2008);
    chk("lone_call_empty", 32'(ras_empty_o), 32'd1);

    // call+ret replaces the top entry
    call = 1; jmp = 1; jmp_target = 32'h700; step(); idle();
    call = 1; ret = 1; jr_target = 32'h555; step(); idle();
    chk("callret_pc", pc_o, 32'h200C);
    chk("callret_nonempty", 32'(ras_empty_o), 32'd0);
    ret = 1; jr_target = 32'h555; step(); idle();
    chk("callret_pop", pc_o, 32'h704);
    chk("callret_empty", 32'(ras_empty_o), 32'd1);

    // stall suppresses RAS push
    stall = 1; call = 1; jmp = 1; jmp_target = 32'hA00; step(); idle();
    chk("stall_call_pc", pc_o, 32'h704);
    chk("stall_call_empty", 32'(ras_empty_o), 32'd1);

    // exceptions
    go_to(32'h50);
    exc = 1; stall = 1; step(); idle();
    chk("exc_pc", pc_o, 32'h180);
    chk("exc_epc", epc_o, 32'h50);
    eret = 1; step(); idle();
    chk("eret_pc", pc_o, 32'h50);
    chk("eret_epc", epc_o, 32'h50);
    exc = 1; step(); idle();
    chk("exc2_epc", epc_o, 32'h50);
    exc = 1; eret = 1; step(); idle();
    chk("exc_eret_pc", pc_o, 32'h180);
    chk("exc_eret_epc", epc_o, 32'h180);

    // reset mid-operation clears the RAS
    call = 1; jmp = 1; jmp_target = 32'h900; step(); idle();
    chk("pre_rst_nonempty", 32'(ras_empty_o), 32'd0);
    rst = 1; step(); rst = 0;
    chk("mid_rst_pc", pc_o, 32'h0);
    chk("mid_rst_empty", 32'(ras_empty_o), 32'd1);
    chk("mid_rst_epc", epc_o, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
